fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each requester's data word and of w_data.
REQ-002 SHALL have parameter NUM_REQ, default 4, legal range 2..8: number of producers sharing one fifo write port.
REQ-003 SHALL have parameter BURST_LEN, default 4, legal range 1..15: maximum accepted beats per grant.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ: bit i high means requester i offers a word.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready, output, NUM_REQ: bit i high means requester i's word is accepted this cycle.
REQ-009 SHALL have port full, input, 1: fifo full flag.
REQ-010 SHALL have port wr, output, 1: fifo write strobe.
REQ-011 SHALL have port w_data, output, DATA_WIDTH: fifo write data.
REQ-012 SHALL have port grant, output, NUM_REQ: registered one-hot (or zero) current owner.
REQ-013 SHALL have port busy, output, 1: high when grant is non-zero.
REQ-014 SHALL have port stall_cnt, output, 16: saturating full-stall counter (see Configuration).

Function
REQ-015 SHALL implement two states: IDLE (grant = 0) and OWN (grant one-hot).
REQ-016 SHALL keep a rotating priority pointer ptr (0..NUM_REQ-1); the arbitration winner is the first set req_valid bit searching ptr, ptr+1, ... modulo NUM_REQ.
REQ-017 IDLE: if any req_valid is high, SHALL move to OWN with grant = winner on the next edge; else stay IDLE. No data accepted in IDLE.
REQ-018 OWN: wr, req_ready[g] and w_data SHALL be combinational: wr = req_valid[g] & ~full; req_ready[g] = wr; w_data = req_data slice g; all other req_ready bits SHALL be 0.
REQ-019 OWN: SHALL count accepted beats (wr high) in a 4-bit beat counter, cleared on every grant change.
REQ-020 OWN: grant SHALL be released at the edge where either the BURST_LEN-th beat is accepted or req_valid[g] is low.
REQ-021 On release SHALL set ptr = (g+1) mod NUM_REQ and re-arbitrate in the same edge using the updated ptr: winner gets grant directly (no idle bubble); if no request, go IDLE.
REQ-022 With a single active requester, release/re-grant SHALL return the grant to that same requester without a gap cycle.
REQ-023 full high in OWN SHALL hold grant, beat counter and ptr unchanged, with wr = 0.
REQ-024 req_valid dropping and full high in the same cycle SHALL release (valid-drop rule dominates).
REQ-025 w_data SHALL be 0 when grant is zero; wr SHALL never be high when full is high.
REQ-026 Beat counter SHALL not wrap; BURST_LEN reached always forces release.

Reset
REQ-027 On reset high, asynchronously: state = IDLE, grant = 0, ptr = 0, beat counter = 0, stall_cnt = 0; hence wr = 0, req_ready = 0, busy = 0, w_data = 0.
REQ-028 Reset asserted mid-burst SHALL abort the grant immediately; no partial-beat state survives; arbitration restarts from ptr = 0 after release.

Configuration
REQ-029 Macro FIFO_WR_ARB_STATS_EN defined: stall_cnt SHALL increment by 1 each cycle in OWN with req_valid[g] and full both high, saturating at 16'hFFFF, cleared only by reset.
REQ-030 Macro FIFO_WR_ARB_STATS_EN undefined: stall_cnt SHALL be constant 0 and no counter logic is built; all other behaviour identical.

Verification
REQ-031 Reset release, req_valid=4'b0100 held, full=0 -> grant=4'b0100 one cycle later, then 4 consecutive wr beats, release, re-grant to requester 2 with no gap cycle.
REQ-032 req_valid=4'b1111 continuous, full=0, BURST_LEN=4 -> grant order 0,1,2,3,0, each exactly 4 wr beats, no idle cycles between owners.
REQ-033 Requester 1 owns, full asserted 3 cycles after 2nd beat -> wr=0 for 3 cycles, grant held, burst completes with beats 3 and 4; stall_cnt=3 with FIFO_WR_ARB_STATS_EN, 0 without.
REQ-034 Requester 3 owns, drops req_valid after 1 beat while requester 0 valid -> next edge grant=4'b0001 (ptr wrapped 3->0).
REQ-035 reset pulsed during 2nd beat of a burst -> grant, wr, busy go 0 immediately; after release with req_valid=4'b0010 -> grant=4'b0010.
REQ-036 Scoreboard over randomised valid/full -> every word presented with req_ready high appears on w_data with wr high, per-requester order preserved, no write while full.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets NUM_REQ producers share a single
// fifo write port. A requester that wins arbitration owns the port for up to
// BURST_LEN accepted beats, or until it drops its valid, then the next
// requester in rotating order takes over on the same edge.
//
// Optional feature: define FIFO_WR_ARB_STATS_EN to build the saturating
// full-stall counter; otherwise stall_cnt is tied to zero.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-high reset
//   req_valid  - per-requester "word offered" flags
//   req_data   - requester i word in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  - per-requester "word accepted this cycle"
//   full       - fifo full flag
//   wr         - fifo write strobe
//   w_data     - fifo write data (zero when nobody owns the port)
//   grant      - registered one-hot owner, zero when idle
//   busy       - high while grant is non-zero
//   stall_cnt  - cycles the owner was blocked by full (saturating)
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [3:0]           beat_q, beat_d;
  logic                 busy_q, busy_d;

  logic                 own_valid;
  logic                 last_beat;
  logic                 release_own;
  logic [PTR_W-1:0]     next_ptr;
  logic [PTR_W-1:0]     arb_ptr;
  logic [PTR_W-1:0]     win;

  // First set bit of v searching p, p+1, ... wrapping at NUM_REQ.
  // Rotating the doubled vector right by p puts candidate p at bit 0.
  function automatic logic [PTR_W-1:0] pick(input logic [NUM_REQ-1:0] v,
                                            input logic [PTR_W-1:0]   p);
    logic [NUM_REQ-1:0] rot;
    logic [PTR_W-1:0]   r;
    logic               found;
    int                 s;
    rot   = NUM_REQ'({v, v} >> p);
    r     = p;
    found = 1'b0;
    s     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s     = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        r     = PTR_W'(s);
      end
    end
    return r;
  endfunction

  // Write path is combinational off the registered grant.
  always_comb begin
    own_valid = |(req_valid & grant_q);
    wr        = (state_q == OWN) && own_valid && !full;
    req_ready = wr ? grant_q : '0;
    w_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Release on the final beat of a burst, or as soon as the owner's valid is
  // low (even while full, so a vanished owner never holds the port).
  always_comb begin
    last_beat   = (beat_q == 4'(BURST_LEN - 1));
    release_own = (state_q == OWN) && (!own_valid || (wr && last_beat));
    next_ptr    = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    // Re-arbitration on release already uses the advanced pointer, so the
    // hand-over happens in one edge with no idle bubble.
    arb_ptr     = release_own ? next_ptr : ptr_q;
    win         = pick(req_valid, arb_ptr);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = OWN;
          grant_d = ONE_HOT0 << win;
          gidx_d  = win;
          beat_d  = '0;
        end
      end
      OWN: begin
        if (release_own) begin
          ptr_d  = next_ptr;
          beat_d = '0;
          if (|req_valid) begin
            grant_d = ONE_HOT0 << win;
            gidx_d  = win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (wr) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  // State register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_q;

  // Stall counter boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == OWN) && own_valid && full && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb (default parameters: 8-bit data,
// 4 requesters, bursts of 4). Directed table, hand-written corner sequences,
// and a randomized phase checked against a behavioural model and a per-
// requester ordering scoreboard.
module tb_fifo_wr_arb;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int BL = 4;

`ifdef FIFO_WR_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [N*DW-1:0] DDATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            full;
  logic            wr;
  logic [DW-1:0]   w_data;
  logic [N-1:0]    grant;
  logic            busy;
  logic [15:0]     stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wr        (wr),
    .w_data    (w_data),
    .grant     (grant),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic [N-1:0] v, input logic f);
    @(negedge clk);
    req_valid = v;
    full      = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    full      = 1'b0;
    req_data  = DDATA;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wdata", 64'(w_data), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  int m_own;   // owning requester, -1 when idle
  int m_ptr;
  int m_beats;
  int m_stall;

  function automatic int pick_m(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (((v >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic logic vbit(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_beats = 0; m_stall = 0;
  endtask

  task automatic model_outputs(output logic [33:0] e, output logic [N-1:0] e_rdy);
    logic          e_wr, e_busy;
    logic [N-1:0]  e_gnt;
    logic [DW-1:0] e_wd;
    logic [15:0]   e_st;
    e_wr = 1'b0; e_busy = 1'b0; e_gnt = '0; e_rdy = '0; e_wd = '0;
    if (m_own >= 0) begin
      e_gnt  = N'(1) << m_own;
      e_busy = 1'b1;
      e_wr   = vbit(req_valid, m_own) && !full;
      e_rdy  = e_wr ? e_gnt : '0;
      e_wd   = req_data[m_own*DW +: DW];
    end
    e_st = STATS ? 16'(m_stall) : 16'd0;
    e = {e_wr, e_rdy, e_gnt, e_busy, e_wd, e_st};
  endtask

  task automatic model_update();
    if (m_own < 0) begin
      m_own   = pick_m(req_valid, m_ptr);
      m_beats = 0;
    end else begin
      if (vbit(req_valid, m_own) && !full) m_beats++;
      if (vbit(req_valid, m_own) && full && m_stall < 65535) m_stall++;
      if (!vbit(req_valid, m_own) || m_beats == BL) begin
        m_ptr   = (m_own + 1) % N;
        m_own   = pick_m(req_valid, m_ptr);
        m_beats = 0;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0]  v;
    logic          f;
    logic          ewr;
    logic [N-1:0]  erdy;
    logic [N-1:0]  egnt;
    logic [DW-1:0] ewd;
  } vec_t;

  vec_t tbl[13];

  int            seq[N];
  int            exp_seq[N];
  bit            pv[N];
  logic [33:0]   e_vec;
  logic [N-1:0]  e_rdy;

  initial begin
    reset = 1'b1; req_valid = '0; full = 1'b0; req_data = DDATA;

    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'hA2};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'hA2};
    tbl[3]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'hA2};
    tbl[4]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'hA2};
    tbl[5]  = '{4'b1100, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'hA2};
    tbl[6]  = '{4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0100, 8'hA2};
    tbl[7]  = '{4'b1001, 1'b0, 1'b1, 4'b1000, 4'b1000, 8'hA3};
    tbl[8]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b1000, 8'hA3};
    tbl[9]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0001, 8'hA0};
    tbl[10] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0001, 8'hA0};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 8'hA0};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].f);
      chk($sformatf("tbl%0d_wr", i),    64'(wr),        64'(tbl[i].ewr));
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].erdy));
      chk($sformatf("tbl%0d_grant", i), 64'(grant),     64'(tbl[i].egnt));
      chk($sformatf("tbl%0d_busy", i),  64'(busy),      64'(|tbl[i].egnt));
      chk($sformatf("tbl%0d_wdata", i), 64'(w_data),    64'(tbl[i].ewd));
    end

    // All four requesting: 0,1,2,3,0 each for exactly four beats, no gaps.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      logic [N-1:0] eg;
      step(4'b1111, 1'b0);
      eg = (c == 0) ? '0 : N'(1) << (((c - 1) / BL) % N);
      chk($sformatf("rr%0d_grant", c), 64'(grant), 64'(eg));
      chk($sformatf("rr%0d_wr", c), 64'(wr), 64'(c != 0));
    end

    // Requester 1 owns, full for 3 cycles after beat 2; stalls are not beats.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      logic f;
      logic [N-1:0] eg;
      logic ew;
      f  = (c >= 3 && c <= 5);
      step((c == 0) ? 4'b0010 : 4'b0011, f);
      eg = (c == 0) ? 4'b0000 : (c == 8) ? 4'b0001 : 4'b0010;
      ew = (c != 0) && !f;
      chk($sformatf("stall%0d_grant", c), 64'(grant), 64'(eg));
      chk($sformatf("stall%0d_wr", c), 64'(wr), 64'(ew));
      if (c == 6) chk("stall_cnt", 64'(stall_cnt), STATS ? 64'd3 : 64'd0);
      if (c == 8) chk("stall_next_wdata", 64'(w_data), 64'hA0);
    end

    // Reset mid-burst aborts immediately, arbitration restarts afterwards.
    do_reset();
    step(4'b0001, 1'b0);
    chk("arst_idle", 64'(grant), 64'd0);
    step(4'b0001, 1'b0);
    chk("arst_beat1", 64'(wr), 64'd1);
    step(4'b0001, 1'b0);
    chk("arst_beat2", 64'(wr), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_wr", 64'(wr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_wdata", 64'(w_data), 64'd0);
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b0010;
    #1;
    chk("arst_after_idle", 64'(grant), 64'd0);
    step(4'b0010, 1'b0);
    chk("arst_regrant", 64'(grant), 64'b0010);

    // Randomized producers that hold a word until it is accepted.
    do_reset();
    model_reset();
    for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; pv[i] = 1'b0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [N-1:0]    v;
      logic [N*DW-1:0] d;
      @(negedge clk);
      v = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) pv[i] = ($urandom_range(0, 99) < 50);
        else if ($urandom_range(0, 99) < 5) pv[i] = 1'b0;
        if (pv[i]) v = v | (N'(1) << i);
        d[i*DW +: DW] = {2'(i), 6'(seq[i])};
      end
      req_valid = v;
      req_data  = d;
      full      = ($urandom_range(0, 99) < 25);
      #1;
      model_outputs(e_vec, e_rdy);
      chk($sformatf("rand%0d_out", cyc),
          64'({wr, req_ready, grant, busy, w_data, stall_cnt}), 64'(e_vec));
      if (wr) begin
        int id;
        id = 0;
        for (int i = 0; i < N; i++) if (grant[i]) id = i;
        chk($sformatf("rand%0d_wr_while_full", cyc), 64'(full), 64'd0);
        chk($sformatf("rand%0d_order", cyc), 64'(w_data), 64'({2'(id), 6'(exp_seq[id])}));
        exp_seq[id]++;
      end
      model_update();
      for (int i = 0; i < N; i++) begin
        if (e_rdy[i]) begin
          seq[i]++;
          pv[i] = ($urandom_range(0, 99) < 70);
        end
      end
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("rand_count_req%0d", i), 64'(exp_seq[i]), 64'(seq[i]));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
